// File: rtl/gpio_input_conditioner.sv
// Per-channel input conditioning: 2-flop synchroniser, consecutive-cycle debouncer and
// registered single-cycle rise/fall pulses for the project core.
module gpio_input_conditioner #(
    parameter  int WIDTH           = 8,
    parameter  int DEBOUNCE_CYCLES = 16,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             any_edge
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0]            level_q, level_d;
    logic [WIDTH-1:0]            rise_q, rise_d;
    logic [WIDTH-1:0]            fall_q, fall_d;
    logic                        any_q, any_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = '0;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2_q[i] != level_q[i]) begin
                    if (cnt_q[i] == CNT_TC) begin
                        // Mismatch has persisted for the full window: accept it.
                        level_d[i] = sync2_q[i];
                        rise_d[i]  = sync2_q[i];
                        fall_d[i]  = ~sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_edge   = any_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench: window-based behavioural model compared every cycle, plus
// hand-computed literal checks along a directed stimulus sequence.
module tb_gpio_input_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b1;
    logic [W-1:0] pin_in = '0;
    logic [W-1:0] level_out, rise_pulse, fall_pulse;
    logic         any_edge;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit chk_en  = 1'b0;

    gpio_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pin_in     (pin_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .any_edge   (any_edge)
    );

    always #5 clk = ~clk;

    // Model: a level is accepted once the last D enabled edges all saw the
    // synchronised pin differ from the held level (window restarts after acceptance).
    logic [W-1:0] m_s1, m_s2, m_lvl, m_rise, m_fall;
    logic         m_any;
    logic [D-1:0] m_win [W];

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
            for (int c = 0; c < W; c++) m_win[c] = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < W; c++) begin
                if (!en) begin
                    m_win[c] = '0;
                end else begin
                    m_win[c] = {m_win[c][D-2:0], (m_s2[c] != m_lvl[c])};
                    if (&m_win[c]) begin
                        m_lvl[c]  = m_s2[c];
                        m_rise[c] = m_s2[c];
                        m_fall[c] = ~m_s2[c];
                        m_win[c]  = '0;
                    end
                end
            end
            m_any = |(m_rise | m_fall);
            m_s2 = m_s1;
            m_s1 = pin_in;
        end
    end

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        cmp_cnt++;
        if (act !== exp_v) begin
            err_cnt++;
            $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("model_level", level_out, m_lvl);
            cmp("model_rise", rise_pulse, m_rise);
            cmp("model_fall", fall_pulse, m_fall);
            cmp("model_any", {3'b000, any_edge}, {3'b000, m_any});
            cmp("rise_fall_excl", rise_pulse & fall_pulse, 4'b0000);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held with all pins high
        pin_in = 4'hF;
        step(2);
        chk_en = 1'b1;
        cmp("rst_level", level_out, 4'h0);
        cmp("rst_rise", rise_pulse, 4'h0);
        cmp("rst_any", {3'b000, any_edge}, 4'h0);
        rst = 1'b0;
        step(5);
        cmp("rel_early_rise", rise_pulse, 4'h0);
        step(1);
        cmp("rel_level", level_out, 4'hF);
        cmp("rel_rise", rise_pulse, 4'hF);
        cmp("rel_any", {3'b000, any_edge}, 4'h1);
        step(1);
        cmp("rel_rise_gone", rise_pulse, 4'h0);

        pin_in = 4'h0;
        step(6);
        cmp("all_fall", fall_pulse, 4'hF);
        step(2);

        // Clean press and release on channel 0
        pin_in = 4'h1;
        step(5);
        cmp("press_early", rise_pulse, 4'h0);
        step(1);
        cmp("press_rise", rise_pulse, 4'h1);
        cmp("press_level", level_out, 4'h1);
        step(2);
        pin_in = 4'h0;
        step(6);
        cmp("release_fall", fall_pulse, 4'h1);
        step(2);

        // Glitch of 3 cycles rejected, 4 cycles accepted
        pin_in = 4'h2;
        step(3);
        pin_in = 4'h0;
        step(10);
        cmp("glitch_level", level_out, 4'h0);
        pin_in = 4'h2;
        step(4);
        pin_in = 4'h0;
        step(2);
        cmp("pulse4_rise", rise_pulse, 4'h2);
        step(10);
        cmp("pulse4_back", level_out, 4'h0);

        // Simultaneous channels
        pin_in = 4'hA;
        step(6);
        cmp("simul_rise", rise_pulse, 4'hA);
        cmp("simul_any", {3'b000, any_edge}, 4'h1);
        step(1);
        cmp("simul_gone", rise_pulse, 4'h0);
        pin_in = 4'h0;
        step(8);

        // Enable dropped mid-count for 3 cycles
        pin_in = 4'h4;
        step(4);
        en = 1'b0;
        step(3);
        cmp("en_low_level", level_out, 4'h0);
        en = 1'b1;
        step(3);
        cmp("en_early", rise_pulse, 4'h0);
        step(1);
        cmp("en_rise", rise_pulse, 4'h4);
        pin_in = 4'h0;
        step(8);

        // Reset while channel 2 is at its last count
        pin_in = 4'h1;
        step(8);
        cmp("pre_rst_level", level_out, 4'h1);
        pin_in = 4'h5;
        step(5);
        rst = 1'b1;
        step(1);
        cmp("midrst_level", level_out, 4'h0);
        cmp("midrst_rise", rise_pulse, 4'h0);
        rst = 1'b0;
        step(8);
        cmp("post_rst_level", level_out, 4'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
